// File: rtl/egg_countdown_pkg.sv
// egg_pkg: shared definitions for the egg-timer countdown.
//   egg_state_e : FSM state encoding (IDLE/RUN/PAUSE/DONE)
//   BCD_ZERO    : 00 in BCD
//   BCD_SEC_MAX : largest legal seconds value (59)
//   bcd_clamp   : force a BCD byte into range (units <= 9, tens <= tens_max)
//   bcd_dec     : decrement a packed MM:SS BCD value, saturating at 00:00
package egg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } egg_state_e;

  localparam logic [7:0]  BCD_ZERO    = 8'h00;
  localparam logic [7:0]  BCD_SEC_MAX = 8'h59;
  localparam logic [15:0] MMSS_ZERO   = 16'h0000;
  localparam logic [15:0] MMSS_ONE    = 16'h0001;

  function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [3:0] tens_max);
    logic [3:0] t;
    logic [3:0] u;
    t = (v[7:4] > tens_max) ? tens_max : v[7:4];
    u = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {t, u};
  endfunction

  // Digit-wise borrow chain: seconds units wrap to 9, seconds tens to 5,
  // minutes units to 9. 00:00 is returned unchanged.
  function automatic logic [15:0] bcd_dec(input logic [15:0] mmss);
    logic [3:0]  mt;
    logic [3:0]  mu;
    logic [3:0]  st;
    logic [3:0]  su;
    logic [15:0] r;
    {mt, mu, st, su} = mmss;
    if (mmss == MMSS_ZERO) begin
      r = mmss;
    end else begin
      if (su != 4'd0) begin
        su = su - 4'd1;
      end else begin
        su = 4'd9;
        if (st != 4'd0) begin
          st = st - 4'd1;
        end else begin
          st = 4'd5;
          if (mu != 4'd0) begin
            mu = mu - 4'd1;
          end else begin
            mu = 4'd9;
            mt = mt - 4'd1;
          end
        end
      end
      r = {mt, mu, st, su};
    end
    return r;
  endfunction

endpackage

// File: rtl/egg_countdown_tick_sync_edge.sv
// tick_sync_edge: brings a slow square wave into the clk_in domain and emits
// a one-cycle strobe on every rising edge of it.
//   clk_in   in  fast clock
//   reset    in  asynchronous active-low reset
//   tick_in  in  slow asynchronous square wave
//   sec_tick out one-cycle strobe per tick_in rising edge
// Parameter SYNC_STAGES (>= 2) sets the synchroniser depth.
module tick_sync_edge
  import egg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset,
  input  logic tick_in,
  output logic sec_tick
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   edge_q;
  logic                   armed_q;
  logic                   sync_out_s;

  assign sync_out_s = sync_q[SYNC_STAGES-1];

  // Synchroniser chain, edge flop and arming logic.
  // The detector is armed only after a genuine low has come out of a fully
  // refilled synchroniser, so a wave that is already high when reset is
  // released does not produce a spurious strobe.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      vld_q   <= '0;
      edge_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], tick_in};
      vld_q   <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      edge_q  <= sync_out_s;
      armed_q <= armed_q | (vld_q[SYNC_STAGES-1] & ~sync_out_s);
    end
  end

  assign sec_tick = sync_out_s & ~edge_q & armed_q;

endmodule

// File: rtl/egg_countdown.sv
// egg_countdown: MM:SS BCD countdown timer driven by a 1 Hz square wave.
//   clk_in           in  fast system clock
//   reset            in  asynchronous active-low reset
//   tick_in          in  1 Hz square wave, one second per rising edge
//   load             in  load min_set/sec_set (clamped to legal BCD)
//   min_set/sec_set  in  BCD preset values
//   start/stop/clear in  control pulses (clear > load > stop > start > tick)
//   min_bcd/sec_bcd  out current count, BCD
//   running          out high in RUN
//   done             out high in DONE
//   alarm            out buzzer/LED drive
// Build option EGG_ALARM_BLINK_EN: alarm blinks for ALARM_TICKS seconds on
// reaching DONE, then holds low. Without it alarm follows done.
module egg_countdown
  import egg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ALARM_TICKS = 10
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       load,
  input  logic [7:0] min_set,
  input  logic [7:0] sec_set,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam logic [7:0] ALARM_RELOAD = 8'(ALARM_TICKS);

  egg_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        alarm_q, alarm_d;
  logic        sec_tick_s;
  logic        cnt_zero_s;
  logic [15:0] load_val_s;

  tick_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_tick (
    .clk_in  (clk_in),
    .reset   (reset),
    .tick_in (tick_in),
    .sec_tick(sec_tick_s)
  );

  assign cnt_zero_s = (cnt_q == MMSS_ZERO);
  assign load_val_s = {bcd_clamp(min_set, 4'd9), bcd_clamp(sec_set, BCD_SEC_MAX[7:4])};

  // Next-state and next-count logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          cnt_d = MMSS_ZERO;
        end else if (load) begin
          cnt_d = load_val_s;
        end else if (stop) begin
          state_d = ST_IDLE;
        end else if (start && !cnt_zero_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // load/start have no effect while counting; stop swallows a
        // coincident tick.
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = MMSS_ZERO;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (sec_tick_s) begin
          cnt_d = bcd_dec(cnt_q);
          if (cnt_q == MMSS_ONE) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (clear) begin
          state_d = ST_IDLE;
          cnt_d   = MMSS_ZERO;
        end else if (load) begin
          cnt_d = load_val_s;
        end else if (stop) begin
          state_d = ST_PAUSE;
        end else if (start && !cnt_zero_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_DONE: begin
        if (clear) begin
          state_d = ST_IDLE;
        end else if (load) begin
          state_d = ST_IDLE;
          cnt_d   = load_val_s;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = MMSS_ZERO;
      end
    endcase
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // State, count and status flag registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= MMSS_ZERO;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

`ifdef EGG_ALARM_BLINK_EN
  logic [7:0] blink_q, blink_d;

  // Blink sequencer: high on entry to DONE, toggles per tick, and the last
  // of the ALARM_TICKS ticks forces it low for good.
  always_comb begin
    blink_d = blink_q;
    alarm_d = alarm_q;
    if (state_d != ST_DONE) begin
      blink_d = 8'd0;
      alarm_d = 1'b0;
    end else if (state_q != ST_DONE) begin
      blink_d = ALARM_RELOAD;
      alarm_d = 1'b1;
    end else if (sec_tick_s && (blink_q != 8'd0)) begin
      blink_d = blink_q - 8'd1;
      alarm_d = (blink_q == 8'd1) ? 1'b0 : ~alarm_q;
    end else begin
      blink_d = blink_q;
    end
  end

  // Blink counter and alarm registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      blink_q <= 8'd0;
      alarm_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      alarm_q <= alarm_d;
    end
  end
`else
  logic unused_alarm_cfg;
  assign unused_alarm_cfg = ^ALARM_RELOAD;

  // Steady alarm: mirrors the DONE state.
  always_comb begin
    alarm_d = (state_d == ST_DONE);
  end

  // Alarm register.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      alarm_q <= 1'b0;
    end else begin
      alarm_q <= alarm_d;
    end
  end
`endif

  assign min_bcd = cnt_q[15:8];
  assign sec_bcd = cnt_q[7:0];
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_egg_countdown.sv
// Scoreboard bench for egg_countdown. A behavioural model tracks the count as
// plain integer seconds; each driven cycle pushes the expected outputs for the
// following clock edge, and a monitor compares them one step after that edge.
module tb_egg_countdown;

  localparam int SYNC_STAGES_TB = 2;
  localparam int ALARM_TICKS_TB = 4;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk_in  = 1'b0;
  logic       reset   = 1'b0;
  logic       tick_in = 1'b0;
  logic       load    = 1'b0;
  logic [7:0] min_set = 8'h00;
  logic [7:0] sec_set = 8'h00;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       clear   = 1'b0;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;

  egg_countdown #(
    .SYNC_STAGES(SYNC_STAGES_TB),
    .ALARM_TICKS(ALARM_TICKS_TB)
  ) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .tick_in(tick_in),
    .load   (load),
    .min_set(min_set),
    .sec_set(sec_set),
    .start  (start),
    .stop   (stop),
    .clear  (clear),
    .min_bcd(min_bcd),
    .sec_bcd(sec_bcd),
    .running(running),
    .done   (done),
    .alarm  (alarm)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    int         edge_no;
    logic [7:0] mn;
    logic [7:0] sc;
    logic       run;
    logic       dn;
    logic       al;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   tick_due[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // reference model state: count in whole seconds
  int m_state = M_IDLE;
  int m_secs  = 0;
  int m_k     = 0;

  function automatic int clampd(input logic [3:0] d, input int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int load_secs(input logic [7:0] ms, input logic [7:0] ss);
    int mins;
    int secs;
    mins = clampd(ms[7:4], 9) * 10 + clampd(ms[3:0], 9);
    secs = clampd(ss[7:4], 5) * 10 + clampd(ss[3:0], 9);
    return mins * 60 + secs;
  endfunction

  function automatic logic alarm_exp();
`ifdef EGG_ALARM_BLINK_EN
    return (m_state == M_DONE) && (m_k < ALARM_TICKS_TB) && (m_k % 2 == 0);
`else
    return (m_state == M_DONE);
`endif
  endfunction

  task automatic m_step(input bit ld, input logic [7:0] ms, input logic [7:0] ss,
                        input bit st, input bit sp, input bit cl, input bit tk);
    int prev;
    prev = m_state;
    if (cl) begin
      if (m_state != M_DONE) m_secs = 0;
      m_state = M_IDLE;
    end else if (ld && m_state != M_RUN) begin
      m_secs  = load_secs(ms, ss);
      if (m_state == M_DONE) m_state = M_IDLE;
    end else if (sp) begin
      if (m_state == M_RUN) m_state = M_PAUSE;
    end else if (st && (m_state == M_IDLE || m_state == M_PAUSE)) begin
      if (m_secs != 0) m_state = M_RUN;
    end else if (tk && m_state == M_RUN) begin
      m_secs = m_secs - 1;
      if (m_secs == 0) m_state = M_DONE;
    end
    if (m_state == M_DONE && prev != M_DONE) m_k = 0;
    else if (m_state == M_DONE && tk) m_k = m_k + 1;
  endtask

  // drive one cycle at the negedge, advance the model, queue the expectation
  task automatic cycle(input bit lvl, input bit ld, input logic [7:0] ms, input logic [7:0] ss,
                       input bit st, input bit sp, input bit cl, input string tag);
    int   e;
    bit   tk;
    exp_t x;
    @(negedge clk_in);
    e = cyc + 1;
    if (lvl && !tick_in) tick_due.push_back(e + SYNC_STAGES_TB);
    tick_in = lvl;
    load    = ld;
    min_set = ms;
    sec_set = ss;
    start   = st;
    stop    = sp;
    clear   = cl;
    tk = 1'b0;
    if (tick_due.size() > 0 && tick_due[0] == e) begin
      tk = 1'b1;
      void'(tick_due.pop_front());
    end
    m_step(ld, ms, ss, st, sp, cl, tk);
    x.edge_no = e;
    x.mn  = to_bcd(m_secs / 60);
    x.sc  = to_bcd(m_secs % 60);
    x.run = (m_state == M_RUN);
    x.dn  = (m_state == M_DONE);
    x.al  = alarm_exp();
    x.tag = tag;
    sbq.push_back(x);
  endtask

  task automatic idle(input int n, input bit lvl);
    for (int i = 0; i < n; i++) cycle(lvl, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "idle");
  endtask

  task automatic tick_pulse();
    idle(3, 1'b1);
    idle(3, 1'b0);
  endtask

  task automatic do_load(input logic [7:0] ms, input logic [7:0] ss, input bit st);
    cycle(1'b0, 1'b1, ms, ss, st, 1'b0, 1'b0, "load");
  endtask

  task automatic do_ctl(input bit st, input bit sp, input bit cl, input string tag);
    cycle(1'b0, 1'b0, 8'h00, 8'h00, st, sp, cl, tag);
  endtask

  task automatic check_zero(input string tag);
    total++;
    if ({min_bcd, sec_bcd, running, done, alarm} !== 19'd0) begin
      bad++;
      $display("FAIL %s got min=%h sec=%h run=%b done=%b alarm=%b want all zero",
               tag, min_bcd, sec_bcd, running, done, alarm);
    end
  endtask

  // monitor: compare every expectation whose edge has just passed
  always @(posedge clk_in) begin
    exp_t x;
    #1;
    cyc++;
    while (sbq.size() > 0 && sbq[0].edge_no <= cyc) begin
      x = sbq.pop_front();
      total++;
      if ({min_bcd, sec_bcd, running, done, alarm} !== {x.mn, x.sc, x.run, x.dn, x.al}) begin
        bad++;
        $display("FAIL %s edge=%0d got min=%h sec=%h run=%b done=%b alarm=%b want min=%h sec=%h run=%b done=%b alarm=%b",
                 x.tag, x.edge_no, min_bcd, sec_bcd, running, done, alarm,
                 x.mn, x.sc, x.run, x.dn, x.al);
      end
    end
  end

  initial begin
    int timer;
    bit lvl;
    bit ld, st, sp, cl;
    logic [7:0] ms, ss;

    repeat (3) @(negedge clk_in);
    check_zero("reset_state");
    reset = 1'b1;
    idle(6, 1'b0);

    // 00:03 countdown to DONE, then alarm behaviour over further ticks
    do_load(8'h00, 8'h03, 1'b0);
    do_ctl(1'b1, 1'b0, 1'b0, "start");
    repeat (3) tick_pulse();
    repeat (5) tick_pulse();
    do_ctl(1'b1, 1'b1, 1'b0, "done_start_stop");
    do_ctl(1'b0, 1'b0, 1'b1, "clear_done");
    idle(2, 1'b0);

    // double borrow and load clamping
    do_load(8'h10, 8'h00, 1'b0);
    do_ctl(1'b1, 1'b0, 1'b0, "start");
    tick_pulse();
    do_ctl(1'b0, 1'b0, 1'b1, "clear_run");
    do_load(8'hA5, 8'h7C, 1'b0);
    idle(2, 1'b0);

    // stop coinciding with the seconds strobe
    do_load(8'h01, 8'h30, 1'b0);
    do_ctl(1'b1, 1'b0, 1'b0, "start");
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "tick_rise");
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, "tick_hold");
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, "stop_on_tick");
    idle(3, 1'b0);
    tick_pulse();
    tick_pulse();
    do_ctl(1'b1, 1'b0, 1'b0, "resume");
    tick_pulse();
    do_ctl(1'b0, 1'b0, 1'b1, "clear");

    // start with a zero count, load+start together
    do_ctl(1'b1, 1'b0, 1'b0, "start_zero");
    do_load(8'h00, 8'h02, 1'b1);
    do_ctl(1'b1, 1'b0, 1'b0, "start_after_load");
    idle(2, 1'b0);
    do_ctl(1'b0, 1'b0, 1'b1, "clear");

    // asynchronous reset mid-run, released with tick_in already high
    do_load(8'h05, 8'h17, 1'b0);
    do_ctl(1'b1, 1'b0, 1'b0, "start");
    tick_pulse();
    @(posedge clk_in);
    #3;
    tick_in = 1'b1;
    reset   = 1'b0;
    #1;
    check_zero("async_reset");
    m_state = M_IDLE;
    m_secs  = 0;
    m_k     = 0;
    tick_due.delete();
    repeat (2) @(negedge clk_in);
    check_zero("reset_hold");
    reset = 1'b1;
    cycle(1'b1, 1'b1, 8'h00, 8'h05, 1'b0, 1'b0, 1'b0, "load_after_rst");
    cycle(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, "start_after_rst");
    idle(6, 1'b1);
    idle(4, 1'b0);
    tick_pulse();
    do_ctl(1'b0, 1'b0, 1'b1, "clear");

    // randomized traffic
    timer = 3;
    lvl   = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (timer == 0) begin
        lvl   = ~lvl;
        timer = $urandom_range(2, 4);
      end else begin
        timer = timer - 1;
      end
      ld = ($urandom % 12 == 0) && (m_state != M_RUN);
      st = ($urandom % 5 == 0);
      sp = ($urandom % 15 == 0);
      cl = ($urandom % 40 == 0);
      ms = ($urandom % 3 == 0) ? 8'($urandom) : {4'd0, 4'($urandom % 2)};
      ss = ($urandom % 3 == 0) ? 8'($urandom) : {4'($urandom % 2), 4'($urandom % 10)};
      cycle(lvl, ld, ms, ss, st, sp, cl, "random");
    end
    idle(3, 1'b0);
    repeat (2) @(negedge clk_in);

    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
